carryskip_subtractor_pipe: RTL and testbench

//   Pipelined carry-skip subtractor: diff = a - b, computed as a + ~b + 1.

---
 rtl/carryskip_subtractor_pipe.sv | 145 ++++++++++++++
 tb/tb_carryskip_subtractor_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/carryskip_subtractor_pipe.sv
// Pipelined carry-skip subtractor (a + ~b + 1), one BLOCK-bit slice per stage, valid/ready both sides.
// Optional SUBSAT_EN: unsigned saturation of out_diff to zero on borrow.
`timescale 1ns/1ps
module carryskip_subtractor_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf
);

  localparam int unsigned N = WIDTH / BLOCK;

  typedef struct packed {
    logic [BLOCK-1:0] sum;
    logic             cout;
  } slice_t;

  function automatic slice_t slice(input logic [BLOCK-1:0] a,
                                   input logic [BLOCK-1:0] b,
                                   input logic             cin);
    logic [BLOCK-1:0] bi;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    slice_t           r;
    r    = '0;
    bi   = ~b;
    p    = a ^ bi;
    g    = a & bi;
    c    = '0;
    c[0] = cin;
    for (int unsigned j = 0; j < BLOCK; j++) begin
      r.sum[j] = p[j] ^ c[j];
      c[j+1]   = g[j] | (p[j] & c[j]);
    end
    r.cout = c[BLOCK] | (&p & cin);
    return r;
  endfunction

  logic [N-1:0] v;
  logic [N:0]   rdy;

  assign rdy[N]    = out_ready;
  assign in_ready  = rdy[0];
  assign out_valid = v[N-1];

  for (genvar gi = 0; gi < N; gi++) begin : g_st
    localparam int unsigned DW   = (gi + 1) * BLOCK;
    localparam int unsigned RW   = WIDTH - DW;
    localparam bit          LAST = (gi == N - 1);

    // src_a/src_b are the operand bits not yet consumed when entering this stage
    logic [RW+BLOCK-1:0] src_a;
    logic [RW+BLOCK-1:0] src_b;
    logic                src_cin;
    logic                src_v;
    logic [DW-1:0]       src_d;
    logic [DW-1:0]       d_nxt;
    logic [DW-1:0]       d_q;
    logic                c_q;
    logic                v_q;
    logic                load;
    slice_t              s;

    if (gi == 0) begin : g_src
      assign src_a   = in_a;
      assign src_b   = in_b;
      assign src_cin = 1'b1;
      assign src_v   = in_valid;
      assign src_d   = s.sum;
    end else begin : g_src
      assign src_a   = g_st[gi-1].g_rem.a_q;
      assign src_b   = g_st[gi-1].g_rem.b_q;
      assign src_cin = g_st[gi-1].c_q;
      assign src_v   = v[gi-1];
      assign src_d   = {s.sum, g_st[gi-1].d_q};
    end

    assign s       = slice(src_a[BLOCK-1:0], src_b[BLOCK-1:0], src_cin);
    assign rdy[gi] = ~v_q | rdy[gi+1];
    assign load    = src_v & rdy[gi];
    assign v[gi]   = v_q;

`ifdef SUBSAT_EN
    assign d_nxt = (LAST && !s.cout) ? '0 : src_d;
`else
    assign d_nxt = src_d;
`endif

    // Inner stages carry the block carry-out; the final stage stores the borrow (~cout) instead
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        c_q <= 1'b0;
      end else begin
        if (rdy[gi]) v_q <= src_v;
        if (load) begin
          d_q <= d_nxt;
          c_q <= LAST ? ~s.cout : s.cout;
        end
      end
    end

    if (RW > 0) begin : g_rem
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= src_a[RW+BLOCK-1:BLOCK];
          b_q <= src_b[RW+BLOCK-1:BLOCK];
        end
      end
    end

    if (LAST) begin : g_fin
      logic c_msb;
      logic ovf_q;
      // carry into the MSB recovered from sum = p ^ c at the top bit
      assign c_msb = s.sum[BLOCK-1] ^ src_a[BLOCK-1] ^ ~src_b[BLOCK-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (load) ovf_q <= c_msb ^ s.cout;
      end
    end
  end

  assign out_diff   = g_st[N-1].d_q;
  assign out_borrow = g_st[N-1].c_q;
  assign out_ovf    = g_st[N-1].g_fin.ovf_q;

endmodule

// File: tb/tb_carryskip_subtractor_pipe.sv
// Self-checking bench for carryskip_subtractor_pipe (WIDTH=8, BLOCK=4): vector table plus scoreboard.
`timescale 1ns/1ps
module tb_carryskip_subtractor_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_diff;
  logic       out_borrow;
  logic       out_ovf;

  always #5 clk = ~clk;

  carryskip_subtractor_pipe #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic res_t sat(input res_t r);
    res_t o;
    o = r;
`ifdef SUBSAT_EN
    if (o.borrow) o.diff = '0;
`endif
    return o;
  endfunction

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    r.diff   = a - b;
    r.borrow = (a < b);
    r.ovf    = (a[7] ^ b[7]) & (r.diff[7] ^ a[7]);
    return sat(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("diff", {24'd0, out_diff}, {24'd0, e.diff});
        chk("borrow", {31'd0, out_borrow}, {31'd0, e.borrow});
        chk("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input res_t exp, output int waited);
    bit ok;
    ok       = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   w;
    int   wsum;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'h05, 8'h03, '{8'h02, 1'b0, 1'b0}};
    vecs[1] = '{8'h10, 8'h01, '{8'h0F, 1'b0, 1'b0}};
    vecs[2] = '{8'h03, 8'h05, '{8'hFE, 1'b1, 1'b0}};
    vecs[3] = '{8'h00, 8'h00, '{8'h00, 1'b0, 1'b0}};
    vecs[4] = '{8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1}};
    vecs[5] = '{8'h00, 8'h01, '{8'hFF, 1'b1, 1'b0}};
    vecs[6] = '{8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b1}};
    vecs[7] = '{8'hFF, 8'hFF, '{8'h00, 1'b0, 1'b0}};
    vecs[8] = '{8'h80, 8'h7F, '{8'h01, 1'b0, 1'b1}};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_diff", {24'd0, out_diff}, 32'd0);
    chk("rst_out_borrow", {31'd0, out_borrow}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // latency: handshake edge E0, result visible after E1
    out_ready = 1'b1;
    send(8'h05, 8'h03, sat('{8'h02, 1'b0, 1'b0}), w);
    chk("lat_after_e0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_after_e1", {31'd0, out_valid}, 32'd1);
    drain();

    // vector table, back to back
    for (int i = 0; i < 9; i++) send(vecs[i].a, vecs[i].b, sat(vecs[i].exp), w);
    drain();

    // backpressure
    out_ready = 1'b0;
    send(8'h20, 8'h01, model(8'h20, 8'h01), w);
    send(8'h30, 8'h02, model(8'h30, 8'h02), w);
    in_valid = 1'b1;
    in_a = 8'h40;
    in_b = 8'h03;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_held", {24'd0, out_diff}, 32'h1F);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h40, 8'h03, model(8'h40, 8'h03), w);
    chk("bp_simul_accept_wait", w, 32'd0);
    drain();

    // streaming
    wsum = 0;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, model(ra, rb), w);
      wsum += w;
    end
    chk("stream_in_ready_stalls", wsum, 32'd0);
    drain();

    // reset mid-flight
    out_ready = 1'b0;
    send(8'h01, 8'h02, model(8'h01, 8'h02), w);
    send(8'h80, 8'h01, model(8'h80, 8'h01), w);
    chk("mid_pre_rst_diff", {24'd0, out_diff}, {24'd0, sat('{8'hFF, 1'b1, 1'b0}).diff});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_diff", {24'd0, out_diff}, 32'd0);
    chk("mid_rst_out_borrow", {31'd0, out_borrow}, 32'd0);
    chk("mid_rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'h55, 8'h22, model(8'h55, 8'h22), w);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
